// File: rtl/full_adder_cell_if.sv
// Operand, control and result signals of one full-adder cell.
// The master drives operands/controls; the cell (slave) returns results.
interface full_adder_cell_if;
   logic a;
   logic b;
   logic cin;
   logic en;
   logic ser_mode;
   logic ser_start;
   logic sum;
   logic co;
   logic sum_q;
   logic co_q;

   modport master (
      output a, b, cin, en, ser_mode, ser_start,
      input  sum, co, sum_q, co_q
   );

   modport slave (
      input  a, b, cin, en, ser_mode, ser_start,
      output sum, co, sum_q, co_q
   );
endinterface

// File: rtl/full_adder_cell.sv
// One-bit full adder with registered outputs and an optional bit-serial mode.
// In serial mode the registered carry feeds back as the next bit's carry-in.
module full_adder_cell #(
   parameter bit SERIAL_EN = 1'b1
) (
   input logic              clk,
   input logic              rst_n,
   full_adder_cell_if.slave bus
);
   logic use_fb;
   logic c_eff;
   logic prop;
   logic gen;
   logic sum_c;
   logic co_c;
   logic sum_r;
   logic co_r;

   // ser_start opens a new word on the external carry; reset clears co_r,
   // so feedback mode sees a zero carry during and after reset.
   assign use_fb = SERIAL_EN && bus.ser_mode && !bus.ser_start;
   assign c_eff  = use_fb ? co_r : bus.cin;

   assign prop  = bus.a ^ bus.b;
   assign gen   = bus.a & bus.b;
   assign sum_c = prop ^ c_eff;
   assign co_c  = gen | (c_eff & prop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_r <= 1'b0;
         co_r  <= 1'b0;
      end else if (bus.en) begin
         sum_r <= sum_c;
         co_r  <= co_c;
      end
   end

   assign bus.sum   = sum_c;
   assign bus.co    = co_c;
   assign bus.sum_q = sum_r;
   assign bus.co_q  = co_r;
endmodule

// File: tb/tb_full_adder_cell.sv
// Directed checks of the full-adder cell: combinational, registered, hold,
// serial word addition, and asynchronous reset in the middle of a word.
module tb_full_adder_cell;
   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   full_adder_cell_if bus ();
   full_adder_cell_if bus2 ();

   full_adder_cell #(.SERIAL_EN(1'b1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   full_adder_cell #(.SERIAL_EN(1'b0)) dut_noser (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus2)
   );

   assign bus2.a         = bus.a;
   assign bus2.b         = bus.b;
   assign bus2.cin       = bus.cin;
   assign bus2.en        = bus.en;
   assign bus2.ser_mode  = bus.ser_mode;
   assign bus2.ser_start = bus.ser_start;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Inputs change on the falling edge, then settle for 1 time unit.
   task automatic drive(input logic a, input logic b, input logic cin,
                        input logic en, input logic sm, input logic ss);
      @(negedge clk);
      bus.a = a; bus.b = b; bus.cin = cin;
      bus.en = en; bus.ser_mode = sm; bus.ser_start = ss;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [1:0] exp8 [8];

   initial begin
      checks = 0;
      errors = 0;
      exp8 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
      bus.a = 0; bus.b = 0; bus.cin = 0; bus.en = 0;
      bus.ser_mode = 0; bus.ser_start = 0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("reset_regs", {bus.co_q, bus.sum_q}, 2'b00);
      chk("reset_comb", {bus.co, bus.sum}, 2'b00);
      tick();
      drive(1, 1, 0, 1, 0, 0);
      chk("comb_in_reset", {bus.co, bus.sum}, 2'b10);
      tick();
      chk("regs_held_in_reset", {bus.co_q, bus.sum_q}, 2'b00);
      @(negedge clk) rst_n = 1'b1;

      // 0+1+0
      drive(0, 1, 0, 1, 0, 0);
      chk("v1_comb", {bus.co, bus.sum}, 2'b01);
      tick();
      chk("v1_regs", {bus.co_q, bus.sum_q}, 2'b01);

      // 1+0+1
      drive(1, 0, 1, 1, 0, 0);
      chk("v2_comb", {bus.co, bus.sum}, 2'b10);
      tick();
      chk("v2_regs", {bus.co_q, bus.sum_q}, 2'b10);

      // Exhaustive with en=0: comb tracks, registers hold across edges
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         drive(v[2], v[1], v[0], 0, 0, 0);
         chk($sformatf("exh_%0d", i), {bus.co, bus.sum}, exp8[i]);
      end
      tick();
      chk("hold_regs", {bus.co_q, bus.sum_q}, 2'b10);

      // ser_start without ser_mode is inert; registers still hold (en=0)
      drive(1, 1, 1, 0, 0, 1);
      chk("start_no_mode", {bus.co, bus.sum}, 2'b11);
      drive(0, 0, 0, 0, 1, 0);
      chk("fb_carry_comb", {bus.co, bus.sum}, 2'b01);
      chk("noser_ignores_mode", {bus2.co, bus2.sum}, 2'b00);

      // Serial 1011 + 0110, LSB first; ser_start overrides co_q=1
      drive(1, 0, 0, 1, 1, 1);
      chk("ser_b0_comb", {bus.co, bus.sum}, 2'b01);
      tick();
      chk("ser_b0", {bus.co_q, bus.sum_q}, 2'b01);
      drive(1, 1, 0, 1, 1, 0);
      chk("ser_b1_comb", {bus.co, bus.sum}, 2'b10);
      tick();
      chk("ser_b1", {bus.co_q, bus.sum_q}, 2'b10);
      drive(0, 1, 0, 1, 1, 0);
      chk("ser_b2_comb", {bus.co, bus.sum}, 2'b10);
      tick();
      chk("ser_b2", {bus.co_q, bus.sum_q}, 2'b10);
      drive(1, 0, 0, 1, 1, 0);
      tick();
      chk("ser_b3", {bus.co_q, bus.sum_q}, 2'b10);

      // Serial word interrupted by reset between clock edges
      drive(1, 1, 0, 1, 1, 1);
      tick();
      chk("mid_b0", {bus.co_q, bus.sum_q}, 2'b10);
      drive(1, 0, 0, 1, 1, 0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_regs", {bus.co_q, bus.sum_q}, 2'b00);
      chk("mid_rst_comb", {bus.co, bus.sum}, 2'b01);
      @(negedge clk) rst_n = 1'b1;

      // 11 + 01 after release: carry starts at 0 even without ser_start
      drive(1, 1, 0, 1, 1, 0);
      tick();
      chk("post_b0", {bus.co_q, bus.sum_q}, 2'b10);
      drive(1, 0, 0, 1, 1, 0);
      tick();
      chk("post_b1", {bus.co_q, bus.sum_q}, 2'b10);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
